stack_alu: RTL



---
 rtl/stack_alu_pkg.sv | 47 ++++
 rtl/stack_alu_exec.sv | 26 ++
 rtl/stack_alu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
// Shared types and per-opcode constants for the operand-stack ALU.
// Opcode depth rules live here so the top only compares numbers.
package stack_alu_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_DUP  = 3'd6,
    OP_DROP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_B,
    S_POP_A,
    S_EXEC,
    S_PUSH_R,
    S_PUSH_2,
    S_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  function automatic logic [1:0] op_need(op_e op);
    case (op)
      OP_PUSH: return 2'd0;
      OP_DUP,
      OP_DROP: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic signed [1:0] op_delta(op_e op);
    case (op)
      OP_PUSH,
      OP_DUP:  return 2'sd1;
      default: return -2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/stack_alu_exec.sv
// Combinational ALU core: R = A op B, modulo 2^W.
// A is the deeper stack operand.
module stack_alu_exec
  import stack_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  always_comb begin
    r = '0;
    case (op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/stack_alu.sv
// Operand-stack execution unit: sequences pops/pushes per opcode
// against an external stack, with a shadow depth for early rejection.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [W-1:0]                 cmd_imm,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [W-1:0]                 stk_wdata,
  input  logic [W-1:0]                 stk_rdata,
  input  logic                         stk_done,
  output logic                         res_valid,
  output logic [W-1:0]                 res_data,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  state_e         state_q, state_d;
  op_e            op_q, op_d, op_in;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [W-1:0]   res_q, res_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           err_q, err_d;
  logic [1:0]     errc_q, errc_d;
  logic [W-1:0]   alu_r;
  logic           under, over;

  stack_alu_exec #(.W(W)) u_exec (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (alu_r)
  );

  assign op_in = op_e'(cmd_op);
  assign under = depth_q < DW'(op_need(op_in));
  assign over  = (op_delta(op_in) == 2'sd1) && (depth_q == DMAX);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    errc_d  = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = op_in;
          if (under) begin
            err_d  = 1'b1;
            errc_d = ERR_UNDER;
          end else if (over) begin
            err_d  = 1'b1;
            errc_d = ERR_OVER;
          end else begin
            case (op_in)
              OP_PUSH: begin
                wdata_d = cmd_imm;
                state_d = S_PUSH_R;
              end
              OP_DUP,
              OP_DROP: state_d = S_POP_A;
              default: state_d = S_POP_B;
            endcase
          end
        end
      end
      S_POP_B: begin
        if (stk_done) begin
          b_d     = stk_rdata;
          depth_d = depth_q - 1'b1;
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        if (stk_done) begin
          a_d     = stk_rdata;
          depth_d = depth_q - 1'b1;
          case (op_q)
            OP_DUP: begin
              wdata_d = stk_rdata;
              state_d = S_PUSH_R;
            end
            OP_DROP: begin
              res_d   = stk_rdata;
              state_d = S_DONE;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        wdata_d = alu_r;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        if (stk_done) begin
          depth_d = depth_q + 1'b1;
          if (op_q == OP_DUP) begin
            state_d = S_PUSH_2;
          end else begin
            res_d   = wdata_q;
            state_d = S_DONE;
          end
        end
      end
      S_PUSH_2: begin
        if (stk_done) begin
          depth_d = depth_q + 1'b1;
          res_d   = wdata_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      a_q     <= '0;
      b_q     <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign stk_pop   = (state_q == S_POP_B) || (state_q == S_POP_A);
  assign stk_push  = (state_q == S_PUSH_R) || (state_q == S_PUSH_2);
  assign stk_wdata = wdata_q;
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;
  assign err       = err_q;
  assign err_code  = errc_q;
  assign depth     = depth_q;

endmodule
